reg_scoreboard: RTL
===================

// Module: reg_scoreboard
// PURPOSE
//  Destination-side tracker for the ID-stage stall logic. Records every issued
//  writeback destination as it moves through EXE/MEM/WB, retires it at register-file write,
//  and answers src1/src2 read-after-write queries with a stall request. Sits beside
//  the ID stage; drives the stall/bubble of IF/ID and the ID/EX pipeline register.
// PARAMETERS
//  ADDR_W   4  register address width (2**ADDR_W architectural registers)
//  STAGES   3  in-flight slots between ID and register-file write (EXE, MEM, WB)
//  CNT_W    2  width of per-register pending counter
// PORTS
//  clk            in   1        rising-edge clock
//  rst            in   1        asynchronous, active-low reset
//  freeze         in   1        pipeline hold (memory wait): slots do not move
//  flush          in   1        branch taken: instruction in ID is not recorded
//  issue_valid    in   1        instruction in ID is a real instruction
//  issue_wb_en    in   1        instruction writes the register file
//  issue_mem_r_en in   1        instruction is a load
//  issue_dest     in   ADDR_W   destination register
//  src1, src2     in   ADDR_W   source registers of the instruction in ID
//  two_src        in   1        src2 is a real operand
//  fwd_en         in   1        forwarding unit active
//  hazard         out  1        stall ID this cycle (combinational)
//  busy_vec       out  2**ADDR_W bit r = register r has a pending write
//  cnt_err        out  1        sticky: pending counter overflow/underflow
// BEHAVIOUR
//  - State: slot[0..STAGES-1] = {valid, dest, load}; slot[0]=EXE, slot[STAGES-1]=WB.
//    pend[r] CNT_W-bit counter per register.
//  - Reset (rst=0, async): all slot.valid=0, pend=0, cnt_err=0; outputs hazard=0,
//    busy_vec=0 while empty.
//  - advance = !freeze. On advance: slot[i]<=slot[i-1]; slot[STAGES-1] retires;
//    slot[0] <= {ins, issue_dest, issue_mem_r_en},
//    ins = issue_valid & issue_wb_en & !hazard & !flush (else bubble, valid=0).
//  - freeze=1: all slots and pend hold; nothing inserted or retired; hazard still
//    evaluated.
//  - pend[r]: +1 when ins with dest r on advance; -1 when valid slot[STAGES-1] with
//    dest r retires; both same cycle same r -> unchanged. busy_vec[r] = (pend[r]!=0).
//  - Overflow (inc at all-ones) or underflow (dec at 0): counter holds, cnt_err<=1
//    until reset.
//  - match(s) = valid slot[i] with dest==s, i in 0..STAGES-2 (WB slot excluded:
//    register file writes first half, reads second half).
//  - fwd_en=0: hazard = match(src1) | (two_src & match(src2)).
//  - fwd_en=1: hazard only for load-use: slot[0].valid & slot[0].load &
//    (slot[0].dest==src1 | (two_src & slot[0].dest==src2)).
//  - hazard is qualified by issue_valid; hazard=0 when issue_valid=0.
//  - Latency: instruction issued at edge N is visible to hazard/busy_vec after
//    edge N; retires STAGES advancing edges later.
//  - Bubble inserted on hazard leaves prior slots advancing so stall self-clears.
// TESTING
//  1 Reset mid-stream with 3 valid slots -> immediately all slots empty, hazard=0,
//    busy_vec=0, cnt_err=0.
//  2 fwd_en=0: issue dest=R3, next cycle src1=R3 -> hazard=1 for 2 cycles (EXE,MEM),
//    0 on 3rd; busy_vec[3]=1 for 3 cycles.
//  3 fwd_en=1: load dest=R5 then src2=R5, two_src=1 -> hazard=1 exactly 1 cycle;
//    same with two_src=0 -> hazard=0; non-load dest=R5 -> hazard=0.
//  4 freeze=1 for 4 cycles with R7 in EXE -> slots/busy_vec unchanged, hazard held 1;
//    release -> normal retirement.
//  5 flush=1 with issue dest=R2 -> nothing recorded, busy_vec[2]=0 next cycle.
//  6 Back-to-back issue dest=R1 x4 with CNT_W=2, STAGES=3 -> pend[1] peaks 3, no
//    cnt_err; force 4 in flight (STAGES=4) -> cnt_err=1.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Destination-register scoreboard beside the ID stage. It tracks writeback destinations
// as they move through EXE/MEM/WB and raises a combinational stall on read-after-write
// hazards. It also keeps a per-register pending count that drives busy_vec.
module reg_scoreboard #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_freeze,
  input  logic                   i_flush,
  input  logic                   i_issue_valid,
  input  logic                   i_issue_wb_en,
  input  logic                   i_issue_mem_r_en,
  input  logic [ADDR_W-1:0]      i_issue_dest,
  input  logic [ADDR_W-1:0]      i_src1,
  input  logic [ADDR_W-1:0]      i_src2,
  input  logic                   i_two_src,
  input  logic                   i_fwd_en,
  output logic                   o_hazard,
  output logic [(1<<ADDR_W)-1:0] o_busy_vec,
  output logic                   o_cnt_err
);

  localparam int unsigned NumRegs  = 1 << ADDR_W;
  localparam int unsigned LastSlot = STAGES - 1;

  // Slot 0 is EXE and slot LastSlot is WB.
  logic [STAGES-1:0] r_slot_valid;
  logic [ADDR_W-1:0] r_slot_dest [STAGES];
  // Only the EXE slot's load flag is ever consulted (load-use), so it is not shifted on.
  logic              r_exe_load;
  logic [CNT_W-1:0]  r_pend [NumRegs];
  logic              r_cnt_err;

  logic               w_raw_hit;
  logic               w_load_use;
  logic               w_ins;
  logic [NumRegs-1:0] w_inc;
  logic [NumRegs-1:0] w_dec;

  // RAW match against EXE..MEM. WB is excluded because the register file writes before it reads.
  always_comb begin
    w_raw_hit = 1'b0;
    for (int unsigned i = 0; i < LastSlot; i++) begin
      if (r_slot_valid[i] &&
          (r_slot_dest[i] == i_src1 || (i_two_src && r_slot_dest[i] == i_src2))) begin
        w_raw_hit = 1'b1;
      end
    end
  end

  assign w_load_use = r_slot_valid[0] && r_exe_load &&
                      (r_slot_dest[0] == i_src1 || (i_two_src && r_slot_dest[0] == i_src2));
  assign o_hazard   = i_issue_valid && (i_fwd_en ? w_load_use : w_raw_hit);
  assign w_ins      = i_issue_valid && i_issue_wb_en && !o_hazard && !i_flush;
  assign o_cnt_err  = r_cnt_err;

  // Per-register increment/decrement requests and the busy view of the counters.
  always_comb begin
    w_inc      = '0;
    w_dec      = '0;
    o_busy_vec = '0;
    for (int unsigned r = 0; r < NumRegs; r++) begin
      w_inc[r]      = w_ins && (i_issue_dest == ADDR_W'(r));
      w_dec[r]      = r_slot_valid[LastSlot] && (r_slot_dest[LastSlot] == ADDR_W'(r));
      o_busy_vec[r] = (r_pend[r] != '0);
    end
  end

  // Slot shift register: insert at EXE and retire out of WB whenever the pipe advances.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot_valid <= '0;
      r_exe_load   <= 1'b0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_slot_dest[i] <= '0;
      end
    end else if (!i_freeze) begin
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_slot_valid[i] <= r_slot_valid[i-1];
        r_slot_dest[i]  <= r_slot_dest[i-1];
      end
      r_slot_valid[0] <= w_ins;
      r_slot_dest[0]  <= i_issue_dest;
      r_exe_load      <= i_issue_mem_r_en;
    end
  end

  // Pending counters: they saturate on overflow/underflow and flag a sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_err <= 1'b0;
      for (int unsigned r = 0; r < NumRegs; r++) begin
        r_pend[r] <= '0;
      end
    end else if (!i_freeze) begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
        if (w_inc[r] && !w_dec[r]) begin
          if (&r_pend[r]) r_cnt_err <= 1'b1;
          else            r_pend[r] <= r_pend[r] + CNT_W'(1);
        end else if (w_dec[r] && !w_inc[r]) begin
          if (r_pend[r] == '0) r_cnt_err <= 1'b1;
          else                 r_pend[r] <= r_pend[r] - CNT_W'(1);
        end
      end
    end
  end

endmodule
